// File: rtl/ir_pkg.sv
`default_nettype none
// ============================================================================
// Module : ir_pkg
// Brief  : NEC IR framing constants, transmitter state type, button->command map
// Rev    : 1.0 - initial release
// ============================================================================
package ir_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LEAD_MARK  = 3'd1,
    S_LEAD_SPACE = 3'd2,
    S_BIT_MARK   = 3'd3,
    S_BIT_SPACE  = 3'd4,
    S_STOP_MARK  = 3'd5,
    S_GAP        = 3'd6
  } tx_state_e;

  localparam int NEC_LEAD_MARK  = 16;
  localparam int NEC_LEAD_SPACE = 8;
  localparam int NEC_ONE_SPACE  = 3;
  localparam int NEC_ZERO_SPACE = 1;
  localparam int NEC_BITS       = 32;

  // Entry 0 is the rightmost byte; shared with the receive-side code decoder.
  localparam logic [15:0][7:0] BTN_TO_CMD = {
    8'h08, 8'h5E, 8'h18, 8'h0C, 8'h0D, 8'h19, 8'h16, 8'h09,
    8'h15, 8'h07, 8'h43, 8'h40, 8'h44, 8'h47, 8'h46, 8'h45
  };

  function automatic logic is_mark(input tx_state_e s);
    return (s == S_LEAD_MARK) || (s == S_BIT_MARK) || (s == S_STOP_MARK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ir_carrier_gen.sv
`default_nettype none
// ============================================================================
// Module : ir_carrier_gen
// Brief  : Registered square-wave carrier, high first after clear, 0 when disabled
// Rev    : 1.0 - initial release
// ============================================================================
module ir_carrier_gen #(
  parameter int CARRIER_HALF = 658
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_carrier
);

  localparam int c_cnt_w = $clog2(CARRIER_HALF + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CARRIER_HALF - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_carrier;

  // Enable/clear describe the coming cycle, so the carrier lines up with the envelope register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cnt     <= '0;
      r_carrier <= 1'b0;
    end else if (!i_enable) begin
      r_cnt     <= '0;
      r_carrier <= 1'b0;
    end else if (i_clear) begin
      r_cnt     <= '0;
      r_carrier <= 1'b1;
    end else if (r_cnt == c_cnt_last) begin
      r_cnt     <= '0;
      r_carrier <= ~r_carrier;
    end else begin
      r_cnt     <= r_cnt + 1'b1;
    end
  end

  assign o_carrier = r_carrier;

endmodule
`default_nettype wire

// File: rtl/ir_encoder_tx.sv
`default_nettype none
// ============================================================================
// Module : ir_encoder_tx
// Brief  : NEC pulse-distance IR transmitter with carrier LED and demod outputs
// Rev    : 1.0 - initial release
// ============================================================================
module ir_encoder_tx
  import ir_pkg::*;
#(
  parameter int         UNIT_CYCLES  = 28125,
  parameter int         CARRIER_HALF = 658,
  parameter logic [7:0] ADDRESS      = 8'h00,
  parameter int         GAP_UNITS    = 72
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_valid,
  input  logic [3:0] i_button,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_ir_envelope,
  output logic       o_ir_led,
  output logic       o_ir_demod
);

  if (UNIT_CYCLES < 2 || CARRIER_HALF < 1 || GAP_UNITS < 1) begin : g_param_check
    $error("ir_encoder_tx: illegal UNIT_CYCLES/CARRIER_HALF/GAP_UNITS");
  end

  localparam int c_max_units = (GAP_UNITS > NEC_LEAD_MARK) ? GAP_UNITS : NEC_LEAD_MARK;
  localparam int c_presc_w   = $clog2(UNIT_CYCLES);
  localparam int c_unit_w    = $clog2(c_max_units + 1);
  localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(UNIT_CYCLES - 1);

  tx_state_e            r_state, w_state_nxt;
  logic [c_presc_w-1:0] r_presc, w_presc_nxt;
  logic [c_unit_w-1:0]  r_units, w_units_nxt, w_len_m1;
  logic [4:0]           r_bit_idx, w_bit_nxt;
  logic [31:0]          r_frame;
  logic [7:0]           w_cmd;
  logic                 w_accept, w_last_clk, w_led;
  logic                 r_ready, r_busy, r_done, r_env, r_demod;

  assign w_accept = i_valid && (r_state == S_IDLE);
  assign w_cmd    = BTN_TO_CMD[i_button];

  always_comb begin
    w_len_m1 = '0;
    case (r_state)
      S_LEAD_MARK:  w_len_m1 = c_unit_w'(NEC_LEAD_MARK - 1);
      S_LEAD_SPACE: w_len_m1 = c_unit_w'(NEC_LEAD_SPACE - 1);
      S_BIT_SPACE:  w_len_m1 = r_frame[r_bit_idx] ? c_unit_w'(NEC_ONE_SPACE - 1)
                                                  : c_unit_w'(NEC_ZERO_SPACE - 1);
      S_GAP:        w_len_m1 = c_unit_w'(GAP_UNITS - 1);
      default:      w_len_m1 = '0;
    endcase
  end

  assign w_last_clk = (r_presc == c_presc_last) && (r_units == w_len_m1);

  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_units_nxt = r_units;
    w_bit_nxt   = r_bit_idx;
    if (r_state == S_IDLE) begin
      if (w_accept) begin
        w_state_nxt = S_LEAD_MARK;
        w_presc_nxt = '0;
        w_units_nxt = '0;
        w_bit_nxt   = '0;
      end
    end else if (w_last_clk) begin
      w_presc_nxt = '0;
      w_units_nxt = '0;
      case (r_state)
        S_LEAD_MARK:  w_state_nxt = S_LEAD_SPACE;
        S_LEAD_SPACE: w_state_nxt = S_BIT_MARK;
        S_BIT_MARK:   w_state_nxt = S_BIT_SPACE;
        S_BIT_SPACE: begin
          // Index wraps 31 -> 0 naturally, leaving it clean for the next frame.
          w_bit_nxt   = r_bit_idx + 1'b1;
          w_state_nxt = (r_bit_idx == 5'(NEC_BITS - 1)) ? S_STOP_MARK : S_BIT_MARK;
        end
        S_STOP_MARK:  w_state_nxt = S_GAP;
        default:      w_state_nxt = S_IDLE;
      endcase
    end else if (r_presc == c_presc_last) begin
      w_presc_nxt = '0;
      w_units_nxt = r_units + 1'b1;
    end else begin
      w_presc_nxt = r_presc + 1'b1;
    end
  end

  // Outputs are registered from next-state values so they track r_state exactly.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state   <= S_IDLE;
      r_presc   <= '0;
      r_units   <= '0;
      r_bit_idx <= '0;
      r_frame   <= '0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_env     <= 1'b0;
      r_demod   <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_presc   <= w_presc_nxt;
      r_units   <= w_units_nxt;
      r_bit_idx <= w_bit_nxt;
      if (w_accept) begin
        r_frame <= {~w_cmd, w_cmd, ~ADDRESS, ADDRESS};
      end
      r_ready   <= (w_state_nxt == S_IDLE);
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= (w_state_nxt == S_GAP) && (w_presc_nxt == c_presc_last)
                   && (w_units_nxt == c_unit_w'(GAP_UNITS - 1));
      r_env     <= is_mark(w_state_nxt);
      r_demod   <= ~is_mark(w_state_nxt);
    end
  end

  ir_carrier_gen #(
    .CARRIER_HALF (CARRIER_HALF)
  ) u_carrier (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_enable  (is_mark(w_state_nxt)),
    .i_clear   (is_mark(w_state_nxt) && !is_mark(r_state)),
    .o_carrier (w_led)
  );

  assign o_ready       = r_ready;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_ir_envelope = r_env;
  assign o_ir_led      = w_led;
  assign o_ir_demod    = r_demod;

endmodule
`default_nettype wire

// File: tb/tb_ir_encoder_tx.sv
`default_nettype none
// ============================================================================
// Module : tb_ir_encoder_tx
// Brief  : Self-checking bench; decodes captured waveforms against NEC timing rules
// Rev    : 1.0 - initial release
// ============================================================================
module tb_ir_encoder_tx;

  localparam int         U    = 4;
  localparam int         CH   = 1;
  localparam int         GAP  = 2;
  localparam logic [7:0] ADDR = 8'h00;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       valid = 1'b0;
  logic [3:0] button = 4'd0;
  logic       ready, busy, done, env, led, demod;

  int checks = 0;
  int errors = 0;

  logic q_env[$], q_led[$], q_demod[$], q_ready[$], q_busy[$], q_done[$];

  ir_encoder_tx #(
    .UNIT_CYCLES  (U),
    .CARRIER_HALF (CH),
    .ADDRESS      (ADDR),
    .GAP_UNITS    (GAP)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_valid       (valid),
    .i_button      (button),
    .o_ready       (ready),
    .o_busy        (busy),
    .o_done        (done),
    .o_ir_envelope (env),
    .o_ir_led      (led),
    .o_ir_demod    (demod)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] ref_cmd(input logic [3:0] b);
    case (b)
      4'd0:  return 8'h45;  4'd1:  return 8'h46;  4'd2:  return 8'h47;  4'd3:  return 8'h44;
      4'd4:  return 8'h40;  4'd5:  return 8'h43;  4'd6:  return 8'h07;  4'd7:  return 8'h15;
      4'd8:  return 8'h09;  4'd9:  return 8'h16;  4'd10: return 8'h19;  4'd11: return 8'h0D;
      4'd12: return 8'h0C;  4'd13: return 8'h18;  4'd14: return 8'h5E;  default: return 8'h08;
    endcase
  endfunction

  function automatic logic [31:0] ref_frame(input logic [3:0] b);
    logic [7:0] c;
    c = ref_cmd(b);
    return {~c, c, ~ADDR, ADDR};
  endfunction

  task automatic send(input logic [3:0] b, input string tag);
    @(negedge clk);
    valid  = 1'b1;
    button = b;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_accept: got %b want 1", tag, ready);
    end
    @(posedge clk);
  endtask

  // Sample index 0 is the first clock after the accepting edge.
  task automatic capture(input bit hold, input bit scramble, output bit tmo);
    q_env.delete(); q_led.delete(); q_demod.delete();
    q_ready.delete(); q_busy.delete(); q_done.delete();
    tmo = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (c == 0 && !hold) valid = 1'b0;
      q_env.push_back(env);     q_led.push_back(led);   q_demod.push_back(demod);
      q_ready.push_back(ready); q_busy.push_back(busy); q_done.push_back(done);
      if (scramble) button = 4'($urandom);
      if (done === 1'b1) begin
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic check_frame(input logic [3:0] b, input bit tmo, input string tag);
    int exp_runs[$];
    int obs_runs[$];
    logic [31:0] frame, dec;
    logic        lvl, exp_led;
    int ones, exp_len, bad, k, dec_btn;
    frame = ref_frame(b);
    ones  = $countones(frame);
    checks++;
    if (tmo) begin
      errors++;
      $display("FAIL %s done_timeout: got no done in %0d clk want done", tag, q_env.size());
      return;
    end
    exp_runs.push_back(16 * U);
    exp_runs.push_back(8 * U);
    for (int i = 0; i < 32; i++) begin
      exp_runs.push_back(U);
      exp_runs.push_back((frame[i] ? 3 : 1) * U);
    end
    exp_runs.push_back(U);
    exp_runs.push_back(GAP * U);
    exp_len = (16 + 8 + 32 * 2 + ones * 2 + 1) * U + GAP * U;

    checks++;
    if (q_env.size() != exp_len) begin
      errors++;
      $display("FAIL %s frame_len: got %0d clk want %0d", tag, q_env.size(), exp_len);
    end

    lvl = 1'b1;
    k   = 0;
    bad = (q_env[0] === 1'b1) ? -1 : 0;
    foreach (q_env[i]) begin
      if (q_env[i] === lvl) k++;
      else begin
        obs_runs.push_back(k);
        lvl = ~lvl;
        k = 1;
      end
    end
    obs_runs.push_back(k);
    if (bad < 0) begin
      for (int i = 0; i < exp_runs.size(); i++) begin
        if (i >= obs_runs.size() || obs_runs[i] != exp_runs[i]) begin
          bad = i;
          break;
        end
      end
      if (bad < 0 && obs_runs.size() != exp_runs.size()) bad = exp_runs.size();
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s envelope_runs: at run %0d got %0d clk want %0d clk (runs %0d/%0d)", tag, bad,
               (bad < obs_runs.size()) ? obs_runs[bad] : -1,
               (bad < exp_runs.size()) ? exp_runs[bad] : -1, obs_runs.size(), exp_runs.size());
    end

    bad = 0;
    foreach (q_env[i]) if (q_demod[i] !== ~q_env[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s demod_complement: got %0d bad cycles want 0", tag, bad);
    end

    bad = 0;
    k   = 0;
    foreach (q_env[i]) begin
      if (q_env[i] === 1'b1) begin
        exp_led = ((k / CH) % 2) == 0;
        k++;
      end else begin
        exp_led = 1'b0;
        k = 0;
      end
      if (q_led[i] !== exp_led) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s led_carrier: got %0d bad cycles want 0", tag, bad);
    end

    bad = 0;
    foreach (q_ready[i]) if (q_ready[i] !== 1'b0 || q_busy[i] !== 1'b1) bad++;
    for (int i = 0; i < q_done.size() - 1; i++) if (q_done[i] !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s busy_handshake: got %0d bad cycles want 0", tag, bad);
    end

    dec     = '0;
    dec_btn = -1;
    if (obs_runs.size() >= 67) begin
      for (int i = 0; i < 32; i++) dec[i] = (obs_runs[3 + 2 * i] > 2 * U);
      for (int j = 0; j < 16; j++) if (ref_cmd(4'(j)) == dec[23:16]) dec_btn = j;
    end
    checks++;
    if (dec_btn != int'(b) || dec[7:0] != ADDR || dec[15:8] != ~dec[7:0] || dec[31:24] != ~dec[23:16]) begin
      errors++;
      $display("FAIL %s decode: got word %h button %0d want word %h button %0d", tag, dec, dec_btn,
               frame, b);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    valid   = 1'b1;
    button  = 4'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({ready, busy, done, env, led, demod} !== 6'b100001) begin
        errors++;
        $display("FAIL reset_hold: got rdy/busy/done/env/led/demod %b want 100001",
                 {ready, busy, done, env, led, demod});
      end
    end
    valid   = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({ready, busy, env, demod} !== 4'b1001) begin
      errors++;
      $display("FAIL reset_release: got rdy/busy/env/demod %b want 1001", {ready, busy, env, demod});
    end
  endtask

  task automatic test_button0();
    bit tmo;
    send(4'd0, "button0");
    capture(1'b0, 1'b0, tmo);
    check_frame(4'd0, tmo, "button0");
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL button0_ready_after_gap: got rdy/busy/done %b want 100", {ready, busy, done});
    end
  endtask

  task automatic test_loopback();
    int order[16];
    int j, t;
    bit tmo;
    for (int i = 0; i < 16; i++) order[i] = i;
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 16; i++) begin
      send(4'(order[i]), $sformatf("loop_btn%0d", order[i]));
      capture(1'b0, 1'b0, tmo);
      check_frame(4'(order[i]), tmo, $sformatf("loop_btn%0d", order[i]));
    end
  endtask

  task automatic test_led();
    logic [3:0] b;
    bit tmo;
    bad_led: begin end
    b = 4'($urandom);
    send(b, "led");
    capture(1'b0, 1'b0, tmo);
    checks++;
    if (q_led.size() < 96 || q_led[0] !== 1'b1 || q_led[1] !== 1'b0 || q_led[2] !== 1'b1
        || q_led[3] !== 1'b0 || q_led[63] !== 1'b0 || q_led[64] !== 1'b0 || q_led[95] !== 1'b0) begin
      errors++;
      $display("FAIL led_lead: got led[0..3]=%b%b%b%b want 1010 then 0 in lead space",
               q_led[0], q_led[1], q_led[2], q_led[3]);
    end
    check_frame(b, tmo, "led");
  endtask

  task automatic test_back_to_back();
    logic [3:0] b1, b2;
    bit tmo;
    b1 = 4'($urandom);
    b2 = 4'($urandom);
    send(b1, "b2b_first");
    capture(1'b1, 1'b1, tmo);
    check_frame(b1, tmo, "b2b_first");
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || env !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_slot: got rdy/env %b%b want 10", ready, env);
    end
    button = b2;
    @(posedge clk);
    capture(1'b0, 1'b0, tmo);
    check_frame(b2, tmo, "b2b_second");
  endtask

  task automatic test_reset_midframe();
    logic [3:0] b;
    logic [31:0] frame;
    int n, bad;
    bit tmo;
    b     = 4'($urandom);
    frame = ref_frame(b);
    n     = 24 * U + 2;
    for (int i = 0; i < 10; i++) n += U + (frame[i] ? 3 : 1) * U;
    send(b, "midreset");
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      if (k == 0) valid = 1'b0;
    end
    checks++;
    if (env !== 1'b1) begin
      errors++;
      $display("FAIL midreset_in_bit10_mark: got env %b want 1", env);
    end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({ready, busy, done, env, led, demod} !== 6'b100001) begin
      errors++;
      $display("FAIL midreset_outputs: got rdy/busy/done/env/led/demod %b want 100001",
               {ready, busy, done, env, led, demod});
    end
    reset_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || ready !== 1'b1 || env !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midreset_quiet: got %0d active cycles want 0", bad);
    end
    send(b, "midreset_resend");
    capture(1'b0, 1'b0, tmo);
    check_frame(b, tmo, "midreset_resend");
  endtask

  initial begin
    test_reset();
    test_button0();
    test_loopback();
    test_led();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
